// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_OFF_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_boot_loader_if.sv
// Valid/ready word stream feeding the boot loader.
interface imem_boot_loader_if;

  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;

  modport master (output ld_valid, output ld_data, output ld_last, input  ld_ready);
  modport slave  (input  ld_valid, input  ld_data, input  ld_last, output ld_ready);

endinterface

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory from address 0, holding the core
// in reset until the last word lands, then hands the memory port to the PC.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  imem_boot_loader_if.slave    ld,
  input  logic [31:0]          pc,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  output logic                 core_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     word_count
);

  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(DEPTH_WORDS - 1);
  localparam logic [BYTE_OFF_W-1:0] OFF_ZERO = '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld.ld_ready = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    core_rst    = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        busy        = 1'b1;
        ld.ld_ready = 1'b1;
        mem_addr    = 32'({cnt_q, OFF_ZERO});
        mem_wdata   = ld.ld_data;
        mem_we      = ld.ld_valid;
        if (ld.ld_valid) begin
          cnt_d = cnt_q + 1'b1;
          // A last word in the final slot is a clean finish, not an overflow.
          if (ld.ld_last) begin
            state_d = RUN;
          end else if (cnt_q == LAST_IDX) begin
            state_d = ERR;
          end
        end
      end

      RUN: begin
        done     = 1'b1;
        core_rst = 1'b0;
        mem_addr = pc;
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      ERR: begin
        err = 1'b1;
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a small instruction memory model.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [31:0]   pc;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_we, core_rst, busy, done, err;
  logic [CW-1:0] word_count;

  int n_cmp = 0;
  int n_err = 0;

  imem_boot_loader_if ld_bus ();

  imem_boot_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ld         (ld_bus),
    .pc         (pc),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rdata;
  always @(posedge clk) if (mem_we) mem[mem_addr[3:2]] <= mem_wdata;
  assign rdata = mem[mem_addr[3:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    ld_bus.ld_valid = v;
    ld_bus.ld_data  = d;
    ld_bus.ld_last  = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_0000;
    reset = 1'b1; start = 1'b0; pc = 32'h0;
    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    step(); step();
    settle();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_ready", ld_bus.ld_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);

    // Basic 3-word load
    reset = 1'b0; start = 1'b1; drive(1'b0, 32'h0, 1'b0);
    step();
    start = 1'b0;
    drive(1'b1, 32'h0050_0093, 1'b0); settle();
    chk("ld0_busy", busy, 1);
    chk("ld0_ready", ld_bus.ld_ready, 1);
    chk("ld0_we", mem_we, 1);
    chk("ld0_addr", mem_addr, 32'h0);
    chk("ld0_wdata", mem_wdata, 32'h0050_0093);
    step();
    drive(1'b1, 32'h00A0_0113, 1'b0); settle();
    chk("ld1_addr", mem_addr, 32'h4);
    step();
    drive(1'b1, 32'h0020_81B3, 1'b1); settle();
    chk("ld2_addr", mem_addr, 32'h8);
    chk("ld2_core_rst", core_rst, 1);
    step();
    drive(1'b0, 32'h0, 1'b0); settle();
    chk("run_done", done, 1);
    chk("run_core_rst", core_rst, 0);
    chk("run_wc", word_count, 3);
    chk("run_busy", busy, 0);
    pc = 32'h0; settle(); chk("rd0", rdata, 32'h0050_0093);
    pc = 32'h4; settle(); chk("rd4", rdata, 32'h00A0_0113);
    pc = 32'h8; settle(); chk("rd8", rdata, 32'h0020_81B3);
    pc = 32'h10; drive(1'b1, 32'h1234_5678, 1'b0); settle();
    chk("run_pc_addr", mem_addr, 32'h10);
    chk("run_we", mem_we, 0);
    chk("run_ready", ld_bus.ld_ready, 0);

    // Reload from RUN with gaps between words
    drive(1'b0, 32'h0, 1'b0);
    start = 1'b1; step(); start = 1'b0; settle();
    chk("rl_core_rst", core_rst, 1);
    chk("rl_busy", busy, 1);
    chk("rl_wc", word_count, 0);
    chk("rl_addr", mem_addr, 32'h0);
    chk("gap0_we", mem_we, 0);
    step(); settle();
    chk("gap0b_we", mem_we, 0);
    chk("gap0b_busy", busy, 1);
    drive(1'b1, 32'hAAAA_0001, 1'b0); settle();
    chk("g0_addr", mem_addr, 32'h0);
    chk("g0_we", mem_we, 1);
    step();
    drive(1'b0, 32'h0, 1'b0); settle();
    chk("gap1_we", mem_we, 0);
    chk("gap1_addr", mem_addr, 32'h4);
    chk("gap1_wc", word_count, 1);
    step();
    drive(1'b1, 32'hBBBB_0002, 1'b0); settle();
    chk("g1_addr", mem_addr, 32'h4);
    step();
    drive(1'b0, 32'h0, 1'b0);
    step(); step(); step(); settle();
    chk("gap3_busy", busy, 1);
    chk("gap3_wc", word_count, 2);
    drive(1'b1, 32'hCCCC_0003, 1'b1); settle();
    chk("g2_addr", mem_addr, 32'h8);
    step();
    drive(1'b0, 32'h0, 1'b0); settle();
    chk("g_done", done, 1);
    chk("g_wc", word_count, 3);
    pc = 32'h0; settle(); chk("grd0", rdata, 32'hAAAA_0001);
    pc = 32'h4; settle(); chk("grd4", rdata, 32'hBBBB_0002);
    pc = 32'h8; settle(); chk("grd8", rdata, 32'hCCCC_0003);

    // Overflow: DEPTH words without last
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h5000_0000 + 32'(i), 1'b0); settle();
      chk("ov_addr", mem_addr, 32'(i * 4));
      step();
    end
    settle();
    chk("ov_err", err, 1);
    chk("ov_wc", word_count, 4);
    chk("ov_core_rst", core_rst, 1);
    chk("ov_ready", ld_bus.ld_ready, 0);
    chk("ov_we", mem_we, 0);
    chk("ov_addr0", mem_addr, 32'h0);
    chk("ov_busy", busy, 0);
    step(); settle();
    chk("ov_hold_err", err, 1);
    chk("ov_hold_wc", word_count, 4);
    drive(1'b0, 32'h0, 1'b0);
    start = 1'b1; step(); start = 1'b0; settle();
    chk("ov_restart_err", err, 0);
    chk("ov_restart_busy", busy, 1);
    chk("ov_restart_wc", word_count, 0);

    // Reset mid-load after two words
    drive(1'b1, 32'h7000_0001, 1'b0); step();
    drive(1'b1, 32'h7000_0002, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0); reset = 1'b1; step();
    reset = 1'b0; drive(1'b1, 32'h7000_0003, 1'b0); settle();
    chk("mr_busy", busy, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_ready", ld_bus.ld_ready, 0);
    chk("mr_wc", word_count, 0);
    chk("mr_core_rst", core_rst, 1);
    chk("mr_addr", mem_addr, 32'h0);
    chk("mr_wdata", mem_wdata, 32'h0);
    step(); settle();
    chk("mr_idle_we", mem_we, 0);
    chk("mr_idle_busy", busy, 0);
    drive(1'b0, 32'h0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    drive(1'b1, 32'h9000_0009, 1'b1); settle();
    chk("mr_new_addr", mem_addr, 32'h0);
    chk("mr_new_we", mem_we, 1);
    step();
    drive(1'b0, 32'h0, 1'b0); pc = 32'h0; settle();
    chk("mr_new_done", done, 1);
    chk("mr_new_wc", word_count, 1);
    chk("mr_new_rd", rdata, 32'h9000_0009);
    pc = 32'h4; settle();
    chk("mr_keep_rd", rdata, 32'h7000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
